// File: rtl/ser_pkg.sv
// Shared types and constants for the block serializer.
// BLOCK_SER_SYNC_EN adds a leading sync byte to every frame.
package ser_pkg;

  localparam int BYTES_PER_BLOCK = 16;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef BLOCK_SER_SYNC_EN
  localparam int FRAME_BYTES = BYTES_PER_BLOCK + 1;
`else
  localparam int FRAME_BYTES = BYTES_PER_BLOCK;
`endif

  localparam int IDX_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } ser_state_t;

  // byte k lives in bits [8k+7:8k]
  typedef logic [BYTES_PER_BLOCK-1:0][7:0] block_t;

endpackage

// File: rtl/block_fifo.sv
// DEPTH-entry block FIFO with registered not-full flag.
// Ports: clk_in, rst_in, push_in, wr_data_in, pop_in, rd_data_out, count_out, ready_out.
module block_fifo
  import ser_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   push_in,
  input  block_t                 wr_data_in,
  input  logic                   pop_in,
  output block_t                 rd_data_out,
  output logic [$clog2(DEPTH):0] count_out,
  output logic                   ready_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  block_t mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q, ready_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push_in && ready_q;
    do_pop   = pop_in && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
    ready_d = (count_d != CW'(DEPTH));
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data_in;
    end
  end

  assign rd_data_out = mem_q[rd_ptr_q];
  assign count_out   = count_q;
  assign ready_out   = ready_q;

endmodule

// File: rtl/block_serializer.sv
// Buffers 128-bit blocks and sends them one byte per pacing tick.
// Ports: block in/ready, tick/enable/busy, byte out/valid, overflow/late flags.
// Define BLOCK_SER_SYNC_EN to prefix each block with sync byte A5.
module block_serializer
  import ser_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       block_valid_in,
  input  block_t     block_in,
  output logic       block_ready_out,
  input  logic       tick_in,
  input  logic       enable_in,
  input  logic       tx_busy_in,
  output logic [7:0] byte_out,
  output logic       byte_valid_out,
  output logic       overflow_out,
  output logic       late_out
);

  localparam int CW = $clog2(DEPTH) + 1;

  ser_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             late_q, late_d;

  block_t           head;
  logic [CW-1:0]    count;
  logic             ready;
  logic             push;
  logic             pop;
  logic [3:0]       data_idx;
  logic [7:0]       cur_byte;
  logic             last;

  block_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .push_in    (block_valid_in),
    .wr_data_in (block_in),
    .pop_in     (pop),
    .rd_data_out(head),
    .count_out  (count),
    .ready_out  (ready)
  );

  assign push = block_valid_in && ready;
  assign last = (idx_q == IDX_W'(FRAME_BYTES - 1));

`ifdef BLOCK_SER_SYNC_EN
  assign data_idx = 4'(idx_q - IDX_W'(1));
  assign cur_byte = (idx_q == '0) ? SYNC_BYTE : head[data_idx];
`else
  assign data_idx = idx_q[3:0];
  assign cur_byte = head[data_idx];
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    late_d  = late_q;
    pop     = 1'b0;
    // a drop is flagged even if a pop frees space this cycle
    ovf_d   = ovf_q | (block_valid_in & ~ready);
    unique case (state_q)
      IDLE: begin
        if (count != '0) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (tick_in) begin
          if (tx_busy_in) begin
            late_d  = 1'b1;
            state_d = HOLD;
          end else begin
            // byte is consumed regardless of enable
            valid_d = enable_in;
            if (enable_in) begin
              byte_d = cur_byte;
            end
            if (last) begin
              pop   = 1'b1;
              idx_d = '0;
              if ((count > CW'(1)) || push) begin
                state_d = SEND;
              end else begin
                state_d = IDLE;
              end
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
      end
      HOLD: begin
        if (!tx_busy_in) begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      idx_q   <= '0;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      late_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      late_q  <= late_d;
    end
  end

  assign block_ready_out = ready;
  assign byte_out        = byte_q;
  assign byte_valid_out  = valid_q;
  assign overflow_out    = ovf_q;
  assign late_out        = late_q;

endmodule

// File: tb/tb_block_serializer.sv
// Self-checking bench for block_serializer against a byte-queue model.
// Honours BLOCK_SER_SYNC_EN when defined.
module tb_block_serializer;
  import ser_pkg::*;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       block_valid_in;
  block_t     block_in;
  logic       block_ready_out;
  logic       tick_in;
  logic       enable_in;
  logic       tx_busy_in;
  logic [7:0] byte_out;
  logic       byte_valid_out;
  logic       overflow_out;
  logic       late_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic       exp_ovf;
  logic       exp_late;
  logic [7:0] last_byte;

  block_serializer #(
    .DEPTH(DEPTH)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst_n),
    .block_valid_in (block_valid_in),
    .block_in       (block_in),
    .block_ready_out(block_ready_out),
    .tick_in        (tick_in),
    .enable_in      (enable_in),
    .tx_busy_in     (tx_busy_in),
    .byte_out       (byte_out),
    .byte_valid_out (byte_valid_out),
    .overflow_out   (overflow_out),
    .late_out       (late_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int nblk();
    return (q.size() + FRAME_BYTES - 1) / FRAME_BYTES;
  endfunction

  function automatic block_t rand_blk();
    block_t b;
    for (int k = 0; k < BYTES_PER_BLOCK; k++) b[k] = 8'($urandom);
    return b;
  endfunction

  task automatic push_blk(input block_t b);
    if (nblk() < DEPTH) begin
`ifdef BLOCK_SER_SYNC_EN
      q.push_back(SYNC_BYTE);
`endif
      for (int k = 0; k < BYTES_PER_BLOCK; k++) q.push_back(b[k]);
    end else begin
      exp_ovf = 1'b1;
    end
    block_in = b;
    block_valid_in = 1'b1;
    cyc();
    block_valid_in = 1'b0;
  endtask

  task automatic settle();
    cyc();
    cyc();
  endtask

  task automatic do_tick(input logic en, input logic busy, input logic rel);
    logic ev;
    ev = 1'b0;
    if (q.size() > 0) begin
      if (busy) begin
        exp_late = 1'b1;
      end else begin
        last_byte = en ? q[0] : last_byte;
        ev = en;
        void'(q.pop_front());
      end
    end
    tick_in = 1'b1;
    enable_in = en;
    tx_busy_in = busy;
    cyc();
    tick_in = 1'b0;
    chk("valid", {31'd0, byte_valid_out}, {31'd0, ev});
    chk("byte", {24'd0, byte_out}, {24'd0, last_byte});
    chk("late", {31'd0, late_out}, {31'd0, exp_late});
    chk("ovf", {31'd0, overflow_out}, {31'd0, exp_ovf});
    chk("ready", {31'd0, block_ready_out}, {31'd0, nblk() < DEPTH});
    cyc();
    chk("pulse_end", {31'd0, byte_valid_out}, 32'd0);
    if (busy && rel) begin
      tx_busy_in = 1'b0;
      settle();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_byte", {24'd0, byte_out}, 32'd0);
    chk("rst_valid", {31'd0, byte_valid_out}, 32'd0);
    chk("rst_ready", {31'd0, block_ready_out}, 32'd1);
    chk("rst_ovf", {31'd0, overflow_out}, 32'd0);
    chk("rst_late", {31'd0, late_out}, 32'd0);
    q.delete();
    exp_ovf = 1'b0;
    exp_late = 1'b0;
    last_byte = 8'h00;
    cyc();
    rst_n = 1'b1;
    settle();
  endtask

  initial begin
    block_t b;
    rst_n = 1'b1;
    block_valid_in = 1'b0;
    block_in = '0;
    tick_in = 1'b0;
    enable_in = 1'b1;
    tx_busy_in = 1'b0;
    exp_ovf = 1'b0;
    exp_late = 1'b0;
    last_byte = 8'h00;
    #3;
    do_reset();

    // incrementing block, full frame, then idle tick
    for (int k = 0; k < BYTES_PER_BLOCK; k++) b[k] = 8'(k);
    push_blk(b);
    settle();
    for (int i = 0; i < FRAME_BYTES; i++) do_tick(1'b1, 1'b0, 1'b1);
    chk("drained", q.size(), 32'd0);
    do_tick(1'b1, 1'b0, 1'b1);

    // three back-to-back pushes into a 2-deep buffer
    push_blk(rand_blk());
    push_blk(rand_blk());
    push_blk(rand_blk());
    cyc();
    chk("ovf_set", {31'd0, overflow_out}, 32'd1);
    for (int i = 0; i < 2 * FRAME_BYTES; i++) do_tick(1'b1, 1'b0, 1'b1);
    chk("ovf_drained", q.size(), 32'd0);

    // busy on tick 5, extra tick while held is ignored
    push_blk(rand_blk());
    settle();
    for (int i = 0; i < 5; i++) do_tick(1'b1, 1'b0, 1'b1);
    do_tick(1'b1, 1'b1, 1'b0);
    do_tick(1'b1, 1'b1, 1'b1);
    while (q.size() > 0) do_tick(1'b1, 1'b0, 1'b1);

    // enable low for the first 8 ticks
    push_blk(rand_blk());
    settle();
    for (int i = 0; i < 8; i++) do_tick(1'b0, 1'b0, 1'b1);
    while (q.size() > 0) do_tick(1'b1, 1'b0, 1'b1);

    // reset mid-block after byte 9
    push_blk(rand_blk());
    push_blk(rand_blk());
    settle();
    for (int i = 0; i < FRAME_BYTES - 6; i++) do_tick(1'b1, 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) do_tick(1'b1, 1'b0, 1'b1);
    push_blk(rand_blk());
    settle();
    while (q.size() > 0) do_tick(1'b1, 1'b0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        push_blk(rand_blk());
        settle();
      end
      do_tick($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 1) == 1);
      tx_busy_in = 1'b0;
      settle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_serializer.md
BLOCK_SERIALIZER -- requirements
Module: block_serializer

Interface
- REQ-001 The block SHALL have parameter DEPTH, default 2, giving the number of 128-bit blocks buffered; legal values are 2, 4 or 8.
- REQ-002 clk_in  input  1  system clock, 98.3 MHz.
- REQ-003 rst_in  input  1  reset, asynchronous, active-low.
- REQ-004 block_valid_in  input  1  single-cycle strobe: an encoded block is present on block_in.
- REQ-005 block_in  input  128 (16x8)  encoded block; byte k is bits [8k+7:8k].
- REQ-006 block_ready_out  output  1  high when the buffer is not full (registered).
- REQ-007 tick_in  input  1  single-cycle 12 kHz pacing strobe.
- REQ-008 enable_in  input  1  transmit enable (button).
- REQ-009 tx_busy_in  input  1  downstream transmitter busy.
- REQ-010 byte_out  output  8  byte to the transmitter.
- REQ-011 byte_valid_out  output  1  single-cycle strobe qualifying byte_out.
- REQ-012 overflow_out  output  1  sticky flag: a block was dropped.
- REQ-013 late_out  output  1  sticky flag: a tick arrived while tx_busy_in was high.

Function
- REQ-014 An accepted block SHALL be pushed into a DEPTH-entry FIFO when block_valid_in=1 and block_ready_out=1.
- REQ-015 When block_valid_in=1 and block_ready_out=0, the block SHALL be dropped and overflow_out SHALL be set, even if a pop occurs in the same cycle.
- REQ-016 The FSM SHALL have three states:
  - IDLE (FIFO empty): goes to SEND on the cycle after the FIFO becomes non-empty, with the byte index at 0.
  - SEND: waits for tick_in.
  - HOLD: entered when a tick finds tx_busy_in=1; left for SEND on the next cycle after tx_busy_in=0.
- REQ-017 In SEND, on tick_in with tx_busy_in=0, byte_out SHALL take the head block's byte[index] on the next cycle, and byte_valid_out SHALL pulse for exactly that cycle if enable_in=1.
- REQ-018 If enable_in=0, the byte SHALL still be consumed on the tick with no valid pulse, so stream timing is preserved.
- REQ-019 In SEND, a tick_in with tx_busy_in=1 SHALL set late_out, leave the index unchanged and move to HOLD; ticks received in HOLD SHALL be ignored.
- REQ-020 After byte 15 is consumed, the FIFO SHALL pop and the state SHALL return to SEND with index 0 if the FIFO is non-empty, else to IDLE.
- REQ-021 Latency from tick_in to byte_valid_out SHALL be exactly 1 cycle.
- REQ-022 byte_out SHALL hold its last value between strobes.
- REQ-023 FIFO pointers SHALL be $clog2(DEPTH) bits wide, with a separate count of $clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH.

Reset
- REQ-024 While rst_in=0, all of the following SHALL hold:
  - state = IDLE
  - FIFO empty, pointers and count = 0
  - index = 0
  - byte_out = 8'h00
  - byte_valid_out = 0
  - block_ready_out = 1
  - overflow_out = 0
  - late_out = 0
- REQ-025 Reset asserted mid-block SHALL discard all buffered and partial data, with no further byte_valid_out pulses.

Configuration
- REQ-026 With BLOCK_SER_SYNC_EN defined, each block SHALL be preceded by sync byte 8'hA5, consumed on its own tick, giving 17 bytes per block with index 0 = sync.
- REQ-027 Without BLOCK_SER_SYNC_EN, exactly 16 bytes per block SHALL be sent, with no sync byte.

Structure
- REQ-028 Package ser_pkg SHALL hold:
  - BYTES_PER_BLOCK = 16
  - SYNC_BYTE = 8'hA5
  - the typedef for the ser_state_t enum (IDLE, SEND, HOLD)
  - the typedef for the block_t packed 16x8 array
- REQ-029 The FIFO SHALL be implemented as sub-module block_fifo, parameterised by DEPTH.

Verification
- REQ-030 The bench SHALL cover these directed scenarios:
  - One block 0x0F0E..0100, enable=1, 16 ticks -> byte_out sequence 00,01..0F, each strobe 1 cycle after its tick, then IDLE.
  - DEPTH=2, three blocks pushed back-to-back before any tick -> third dropped, overflow_out=1, first two blocks emitted intact (32 bytes).
  - tx_busy_in=1 on tick 5 -> late_out=1, no strobe; after busy drops, the next tick emits byte 5.
  - enable_in=0 for ticks 0-7, then 1 -> no strobes for bytes 0-7, strobes for bytes 8-15 only.
  - rst_in pulsed low after byte 9 -> all outputs at reset values, and no strobes on later ticks until a new block arrives.
  - BLOCK_SER_SYNC_EN defined -> first strobe carries A5, followed by 16 data bytes (17 strobes per block).
